level_recorder: RTL and testbench
=================================

Name: level_recorder

Overview:
Records a player-performed rhythm into a 12-slot level code. This is the writer end of the level-code interface; the input handler is the reader.
- Samples key presses over fixed-length beat slots.
- Packs slot 0 into the MSB so the input handler's MSB-first left-rotation replays the pattern in the same order.
- Sits between the key debouncer and the level store.

Parameters:
SLOTS, 12, number of beat slots per level; also the width of level_code
TICKS_PER_SLOT, 25000000, clock cycles per slot (use 4 in simulation)
CNT_W, 26, width of the slot tick counter; must satisfy 2^CNT_W > TICKS_PER_SLOT

Ports:
clock  in  1  system clock, rising edge
resetn  in  1  synchronous active-low reset
start  in  1  one-cycle pulse; begins a recording when idle
abort  in  1  one-cycle pulse; discards the recording in progress
user_input  in  1  debounced key level
level_code  out  SLOTS  last completed recording; slot 0 in the MSB
code_valid  out  1  one-cycle pulse when level_code updates
busy  out  1  high while recording
slot_idx  out  4  current slot, 0..SLOTS-1
beat  out  1  slot-start pulse (see Optional Feature)

Behaviour:
- Reset (resetn=0 at a clock edge):
  - state IDLE; level_code=0, code_valid=0, busy=0, slot_idx=0, beat=0.
  - Internal shift register, tick counter and hit flag are all cleared.
  - Reset mid-recording discards all partial data.
- FSM states: IDLE, RECORD.
- IDLE → RECORD on start=1:
  - tick counter=0, slot_idx=0, shift=0, hit=0.
  - busy=1 from the next cycle.
- RECORD:
  - Tick counter increments each cycle.
  - slot_end is true when counter == TICKS_PER_SLOT-1. On that edge: counter→0, shift <= {shift[SLOTS-2:0], hit}, hit→0, slot_idx increments.
- Hit detection:
  - A rising edge of user_input (registered previous value 0, current value 1) sets hit.
  - Holding the key does not re-trigger. Multiple presses in one slot still yield a single 1.
  - A rising edge on the same cycle as slot_end counts toward the next slot.
- Final slot (slot_end while slot_idx == SLOTS-1):
  - level_code <= {shift[SLOTS-2:0], hit}; code_valid=1 for exactly the following cycle.
  - state → IDLE; busy=0; slot_idx=0.
- Timing: total recording length is SLOTS*TICKS_PER_SLOT cycles from the cycle after start is accepted.
- start while in RECORD is ignored (no restart).
- abort in RECORD:
  - Next cycle: IDLE, busy=0, slot_idx=0.
  - level_code keeps its previous value; no code_valid pulse.
- Simultaneous abort and final slot_end: abort wins; no update.
- abort in IDLE has no effect.
- level_code holds its value indefinitely between recordings.
- In IDLE, user_input is ignored, but the previous-value register still tracks it. A key held across start therefore does not count as a press.

Optional Feature:
LEVEL_RECORDER_METRONOME_EN
- Defined: beat=1 for one cycle on the first cycle of each slot. That is the cycle after start is accepted and the cycle after each non-final slot_end, so SLOTS pulses per recording. Used to drive a metronome tone or LED.
- Undefined: beat is tied to 0 and the pulse logic is not built.

Decomposition:
- Shared package piano_pkg holds:
  - constant LEVEL_SLOTS=12;
  - typedef level_code_t (logic [LEVEL_SLOTS-1:0]);
  - typedef enum rec_state_t {REC_IDLE, REC_RECORD}.
- One sub-module, slot_timer: the tick counter with enable/clear, producing a slot_end pulse. It is reusable by the playback side.
- Edge detection and the FSM stay in level_recorder.

Test Plan:
(All scenarios use TICKS_PER_SLOT=4, SLOTS=12.)
- Press once in slots 0, 2 and 11 → after 48 cycles level_code=12'hA01, code_valid high for exactly 1 cycle, busy falls the same cycle.
- Key held high continuously from slot 3 through slot 6 → only slot 3 is set: level_code=12'h100.
- Record 12'hFFF (press every slot), then start a new recording and abort at slot 5 → level_code stays 12'hFFF, no code_valid pulse.
- Press edge exactly on a slot_end cycle of slot 4 → bit for slot 5 set: level_code=12'h040.
- resetn=0 at slot 7 of a recording → all outputs 0 next cycle; a subsequent start records cleanly from slot 0.
- With LEVEL_RECORDER_METRONOME_EN defined, one recording → exactly 12 beat pulses spaced 4 cycles apart; without the macro → beat never asserted.

Source files
------------

// File: rtl/piano_pkg.sv
// Shared level-code types for the recorder (writer) and input handler (reader).
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package piano_pkg;

    localparam int LEVEL_SLOTS = 12;

    typedef logic [LEVEL_SLOTS-1:0] level_code_t;

    typedef enum logic {
        REC_IDLE   = 1'b0,
        REC_RECORD = 1'b1
    } rec_state_t;

endpackage

// File: rtl/level_recorder_slot_timer.sv
// Slot tick counter: counts enabled cycles and flags the last tick of each slot.
// Latency: slot_end is combinational on the counter value; the count wraps on the same edge.
// Backpressure: none; enable freezes the count, clear forces it to zero.
//
// Ports:
//   clock, resetn  rising-edge clock, synchronous active-low reset
//   enable         count this cycle
//   clear          force the count to zero (takes priority over enable)
//   slot_end       high on the final tick of a slot while enabled
module slot_timer #(
    parameter int TICKS_PER_SLOT = 25000000,
    parameter int CNT_W          = 26
) (
    input  logic clock,
    input  logic resetn,
    input  logic enable,
    input  logic clear,
    output logic slot_end
);

    localparam logic [CNT_W-1:0] LAST_TICK = CNT_W'(TICKS_PER_SLOT - 1);

    logic [CNT_W-1:0] tick_count;

    assign slot_end = enable && (tick_count == LAST_TICK);

    always_ff @(posedge clock) begin
        if (!resetn || clear) begin
            tick_count <= '0;
        end else if (enable) begin
            if (slot_end) begin
                tick_count <= '0;
            end else begin
                tick_count <= tick_count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/level_recorder.sv
// Records key presses over SLOTS beat slots into a level code, slot 0 in the MSB.
// Latency: SLOTS*TICKS_PER_SLOT cycles from the cycle after start to the code_valid pulse.
// Backpressure: none; start is ignored while busy, abort drops the recording in progress.
//
// Ports:
//   clock, resetn  rising-edge clock, synchronous active-low reset
//   start, abort   one-cycle command pulses
//   user_input     debounced key level
//   level_code     last completed recording (held between recordings)
//   code_valid     one-cycle pulse when level_code updates
//   busy           high while recording
//   slot_idx       current slot number
//   beat           slot-start pulse, only built when LEVEL_RECORDER_METRONOME_EN is
//                  defined; tied low otherwise
module level_recorder
    import piano_pkg::*;
#(
    parameter int SLOTS          = LEVEL_SLOTS,
    parameter int TICKS_PER_SLOT = 25000000,
    parameter int CNT_W          = 26
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             start,
    input  logic             abort,
    input  logic             user_input,
    output logic [SLOTS-1:0] level_code,
    output logic             code_valid,
    output logic             busy,
    output logic [3:0]       slot_idx,
    output logic             beat
);

    localparam logic [3:0] LAST_SLOT = 4'(SLOTS - 1);

    rec_state_t       state;
    // Holds completed slots only; the in-progress slot lives in hit, so the
    // final code is {shift, hit} and no shifted-out bit is ever stored.
    logic [SLOTS-2:0] shift;
    logic             hit;
    logic             key_prev;
    logic             key_rise;
    logic             recording;
    logic             slot_end;

    assign recording = (state == REC_RECORD);
    assign key_rise  = user_input & ~key_prev;

    slot_timer #(
        .TICKS_PER_SLOT(TICKS_PER_SLOT),
        .CNT_W         (CNT_W)
    ) u_slot_timer (
        .clock   (clock),
        .resetn  (resetn),
        .enable  (recording),
        .clear   (!recording),
        .slot_end(slot_end)
    );

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state      <= REC_IDLE;
            level_code <= '0;
            code_valid <= 1'b0;
            busy       <= 1'b0;
            slot_idx   <= '0;
            shift      <= '0;
            hit        <= 1'b0;
            key_prev   <= 1'b0;
        end else begin
            // Tracks the key even when idle so a key held across start is not a press.
            key_prev   <= user_input;
            code_valid <= 1'b0;
            case (state)
                REC_IDLE: begin
                    if (start) begin
                        state    <= REC_RECORD;
                        busy     <= 1'b1;
                        slot_idx <= '0;
                        shift    <= '0;
                        hit      <= 1'b0;
                    end
                end
                REC_RECORD: begin
                    if (abort) begin
                        state    <= REC_IDLE;
                        busy     <= 1'b0;
                        slot_idx <= '0;
                    end else if (slot_end) begin
                        // A rise on the boundary cycle belongs to the next slot.
                        hit <= key_rise;
                        if (slot_idx == LAST_SLOT) begin
                            level_code <= {shift, hit};
                            code_valid <= 1'b1;
                            state      <= REC_IDLE;
                            busy       <= 1'b0;
                            slot_idx   <= '0;
                        end else begin
                            shift    <= {shift[SLOTS-3:0], hit};
                            slot_idx <= slot_idx + 4'd1;
                        end
                    end else if (key_rise) begin
                        hit <= 1'b1;
                    end
                end
                default: state <= REC_IDLE;
            endcase
        end
    end

`ifdef LEVEL_RECORDER_METRONOME_EN
    logic beat_q;

    // Fires on the first cycle of every slot: after an accepted start and after
    // each non-final, non-aborted slot boundary.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            beat_q <= 1'b0;
        end else begin
            beat_q <= (!recording && start) ||
                      (recording && !abort && slot_end && (slot_idx != LAST_SLOT));
        end
    end

    assign beat = beat_q;
`else
    assign beat = 1'b0;
`endif

endmodule

// File: tb/tb_level_recorder.sv
// Self-checking bench for level_recorder with TICKS_PER_SLOT=4, SLOTS=12.
// Latency: n/a.
// Backpressure: n/a.
module tb_level_recorder;

    localparam int SLOTS = 12;
    localparam int TPS   = 4;
    localparam int NCYC  = SLOTS * TPS;

    localparam int END_NONE  = 0;
    localparam int END_ABORT = 1;
    localparam int END_RESET = 2;

`ifdef LEVEL_RECORDER_METRONOME_EN
    localparam bit METRO = 1'b1;
`else
    localparam bit METRO = 1'b0;
`endif

    logic             clock = 1'b0;
    logic             resetn;
    logic             start;
    logic             abort;
    logic             user_input;
    logic [SLOTS-1:0] level_code;
    logic             code_valid;
    logic             busy;
    logic [3:0]       slot_idx;
    logic             beat;

    int n_cmp = 0;
    int n_err = 0;
    logic [SLOTS-1:0] last_code = '0;

    always #5 clock = ~clock;

    level_recorder #(
        .SLOTS         (SLOTS),
        .TICKS_PER_SLOT(TPS),
        .CNT_W         (3)
    ) dut (
        .clock     (clock),
        .resetn    (resetn),
        .start     (start),
        .abort     (abort),
        .user_input(user_input),
        .level_code(level_code),
        .code_valid(code_valid),
        .busy      (busy),
        .slot_idx  (slot_idx),
        .beat      (beat)
    );

    typedef struct {
        string            name;
        logic [NCYC-1:0]  keys;
        bit               pre;
        int               end_kind;
        int               end_at;
        logic [SLOTS-1:0] exp_code;
    } vec_t;

    task automatic chk(input string what, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", what, act, exp);
        end
    endtask

    function automatic logic [NCYC-1:0] pulse(input int t);
        logic [NCYC-1:0] one = 1;
        return one << t;
    endfunction

    function automatic logic [NCYC-1:0] span(input int a, input int b);
        logic [NCYC-1:0] m = '0;
        for (int i = a; i <= b; i++) m[i] = 1'b1;
        return m;
    endfunction

    // Reference: each press edge lands in the slot of its cycle, except that an
    // edge on a slot's last tick belongs to the following slot (lost after slot 11).
    function automatic logic [SLOTS-1:0] model(input logic [NCYC-1:0] keys, input bit pre);
        logic [SLOTS-1:0] code = '0;
        bit prev = pre;
        int slot;
        for (int t = 0; t < NCYC; t++) begin
            if (keys[t] && !prev) begin
                slot = t / TPS + ((t % TPS == TPS - 1) ? 1 : 0);
                if (slot < SLOTS) code[SLOTS-1-slot] = 1'b1;
            end
            prev = keys[t];
        end
        return code;
    endfunction

    task automatic run_rec(input string name, input logic [NCYC-1:0] keys, input bit pre,
                           input int end_kind, input int end_at, input logic [SLOTS-1:0] exp_code);
        int beats = 0;
        int last_t = NCYC - 1;
        @(negedge clock);
        user_input = pre;
        start      = 1'b1;
        for (int t = 0; t < NCYC; t++) begin
            @(negedge clock);
            start = (t == 17);
            chk($sformatf("%s busy t=%0d", name, t), 32'(busy), 32'd1);
            chk($sformatf("%s slot_idx t=%0d", name, t), 32'(slot_idx), 32'(t / TPS));
            chk($sformatf("%s code_valid t=%0d", name, t), 32'(code_valid), 32'd0);
            chk($sformatf("%s beat t=%0d", name, t), 32'(beat), 32'(METRO && (t % TPS == 0)));
            if (beat) beats++;
            user_input = keys[t];
            if (end_kind == END_ABORT && t == end_at) abort = 1'b1;
            if (end_kind == END_RESET && t == end_at) resetn = 1'b0;
            if (end_kind != END_NONE && t == end_at) begin
                last_t = t;
                break;
            end
        end
        @(negedge clock);
        chk($sformatf("%s end busy t=%0d", name, last_t), 32'(busy), 32'd0);
        chk($sformatf("%s end slot_idx", name), 32'(slot_idx), 32'd0);
        chk($sformatf("%s end beat", name), 32'(beat), 32'd0);
        chk($sformatf("%s end level_code", name), 32'(level_code), 32'(exp_code));
        chk($sformatf("%s end code_valid", name), 32'(code_valid), 32'(end_kind == END_NONE));
        if (end_kind == END_NONE) begin
            chk($sformatf("%s beat count", name), 32'(beats), METRO ? 32'(SLOTS) : 32'd0);
        end
        start      = 1'b0;
        resetn     = 1'b1;
        user_input = 1'b0;
        abort      = 1'b1;   // abort while idle must be harmless
        @(negedge clock);
        abort = 1'b0;
        chk($sformatf("%s after code_valid", name), 32'(code_valid), 32'd0);
        chk($sformatf("%s after busy", name), 32'(busy), 32'd0);
        chk($sformatf("%s held level_code", name), 32'(level_code), 32'(exp_code));
        last_code = exp_code;
    endtask

    vec_t vecs[10];

    initial begin
        logic [NCYC-1:0] all_slots;
        logic [NCYC-1:0] rkeys;
        logic [SLOTS-1:0] rexp;
        int rkind;
        int rat;
        bit rpre;

        all_slots = '0;
        for (int s = 0; s < SLOTS; s++) all_slots |= pulse(s * TPS + 1);

        vecs[0] = '{"slots_0_2_11",   pulse(0) | pulse(8) | pulse(44), 1'b0, END_NONE,  0,  12'hA01};
        vecs[1] = '{"held_3_to_6",    span(12, 27),                    1'b0, END_NONE,  0,  12'h100};
        vecs[2] = '{"all_slots",      all_slots,                       1'b0, END_NONE,  0,  12'hFFF};
        vecs[3] = '{"abort_slot5",    all_slots,                       1'b0, END_ABORT, 21, 12'hFFF};
        vecs[4] = '{"edge_on_end",    pulse(19),                       1'b0, END_NONE,  0,  12'h040};
        vecs[5] = '{"held_at_start",  span(0, 5),                      1'b1, END_NONE,  0,  12'h000};
        vecs[6] = '{"abort_final",    pulse(2),                        1'b0, END_ABORT, 47, 12'h000};
        vecs[7] = '{"rise_last_end",  pulse(45) | pulse(47),           1'b0, END_NONE,  0,  12'h001};
        vecs[8] = '{"reset_slot7",    pulse(0),                        1'b0, END_RESET, 28, 12'h000};
        vecs[9] = '{"after_reset",    pulse(0) | pulse(4),             1'b0, END_NONE,  0,  12'hC00};

        resetn     = 1'b0;
        start      = 1'b0;
        abort      = 1'b0;
        user_input = 1'b0;
        repeat (2) @(negedge clock);
        chk("reset level_code", 32'(level_code), 32'd0);
        chk("reset code_valid", 32'(code_valid), 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset slot_idx", 32'(slot_idx), 32'd0);
        chk("reset beat", 32'(beat), 32'd0);
        resetn = 1'b1;
        @(negedge clock);

        for (int i = 0; i < 10; i++) begin
            run_rec(vecs[i].name, vecs[i].keys, vecs[i].pre,
                    vecs[i].end_kind, vecs[i].end_at, vecs[i].exp_code);
        end

        for (int r = 0; r < 12; r++) begin
            for (int t = 0; t < NCYC; t++) rkeys[t] = ($urandom_range(0, 3) == 0);
            rpre  = 1'($urandom_range(0, 1));
            rkind = ($urandom_range(0, 3) == 0) ? END_ABORT : END_NONE;
            rat   = $urandom_range(0, NCYC - 1);
            rexp  = (rkind == END_ABORT) ? last_code : model(rkeys, rpre);
            run_rec($sformatf("rand%0d", r), rkeys, rpre, rkind, rat, rexp);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
